// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4 -- four-channel time-division demultiplexer
//
// A serial stream carries one bit per sampled slot. A frame starts with the
// slot-0 bit, marked by sync, and the next bits fill slots 1..3. When the
// last slot is accepted, the four bits are moved to the registered channel
// outputs together and frame_valid pulses for one cycle. Early syncs, missing
// syncs and mid-frame stalls longer than IDLE_TIMEOUT cycles drop the partial
// frame and pulse sync_err. A dropped frame never changes the outputs.
//
// Optional feature (macro TDM_DEMUX4_PARITY_EN):
//   When this macro is defined, the frame has a fifth slot (slot 4) that
//   carries even parity over a..d. On a parity mismatch the frame is dropped
//   and par_err pulses. When the macro is not defined, par_err is always 0.
//
// Parameters:
//   IDLE_TIMEOUT  number of clk cycles without en, mid-frame, that ends the
//                 frame (2..255)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          serial data, one slot per sampled bit
//   sync         frame marker, high on the slot-0 bit
//   en           sample strobe; din/sync are used only when en=1
//   a, b, c, d   registered channel outputs for slots 0..3
//   slot         index of the slot the next sampled bit will fill
//   frame_valid  one-cycle pulse in the cycle a..d show a new frame
//   sync_err     one-cycle pulse on a framing fault
//   par_err      one-cycle pulse on a parity fault
// -----------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       sync,
    input  logic       en,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [2:0] slot,
    output logic       frame_valid,
    output logic       sync_err,
    output logic       par_err
);

`ifdef TDM_DEMUX4_PARITY_EN
    localparam logic [2:0] LAST_SLOT = 3'd4;
`else
    localparam logic [2:0] LAST_SLOT = 3'd3;
`endif
    // The shadow holds the slots that arrive before the last slot.
    localparam int SW = int'(LAST_SLOT);
    localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_TIMEOUT - 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t          state_q, state_d;
    logic [2:0]      slot_d;
    logic [SW-1:0]   shadow_q, shadow_d;
    logic [7:0]      idle_q, idle_d;
    logic            armed_q;
    logic [3:0]      data_d;       // {a, b, c, d}
    logic [3:0]      frame_bits;   // complete frame if this edge accepts the last slot
    logic            fv_d, se_d, pe_d;
    logic            sample;

    // The sample qualifier stays low until the first clock edge after reset
    // has been released. Because of this, an en that arrives on that edge, or
    // earlier, is never used.
    assign sample = en & armed_q;

`ifdef TDM_DEMUX4_PARITY_EN
    logic parity_ok;
    assign frame_bits = {shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3]};
    assign parity_ok  = ~(^shadow_q ^ din);
`else
    assign frame_bits = {shadow_q[0], shadow_q[1], shadow_q[2], din};
`endif

    // NOTE: every signal driven here gets a default value first. Without
    // this, a path that skips an assignment would infer a latch.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot;
        shadow_d = shadow_q;
        idle_d   = idle_q;
        data_d   = {a, b, c, d};
        fv_d     = 1'b0;
        se_d     = 1'b0;
        pe_d     = 1'b0;

        unique case (state_q)
            HUNT: begin
                idle_d = '0;
                slot_d = '0;
                if (sample && sync) begin
                    shadow_d[0] = din;
                    slot_d      = 3'd1;
                    state_d     = RECV;
                end
            end

            RECV: begin
                if (sample) begin
                    idle_d = '0;
                    if (slot == 3'd0) begin
                        if (sync) begin
                            shadow_d[0] = din;
                            slot_d      = 3'd1;
                        end else begin
                            se_d    = 1'b1;
                            slot_d  = '0;
                            state_d = HUNT;
                        end
                    end else if (sync) begin
                        // Early sync: drop the partial frame and treat this
                        // bit as the new slot 0. If the parity slot is bad as
                        // well, the parity fault is reported in place of the
                        // sync fault.
`ifdef TDM_DEMUX4_PARITY_EN
                        if (slot == LAST_SLOT && !parity_ok) pe_d = 1'b1;
                        else                                 se_d = 1'b1;
`else
                        se_d = 1'b1;
`endif
                        shadow_d[0] = din;
                        slot_d      = 3'd1;
                    end else if (slot == LAST_SLOT) begin
                        slot_d = '0;
`ifdef TDM_DEMUX4_PARITY_EN
                        if (parity_ok) begin
                            data_d = frame_bits;
                            fv_d   = 1'b1;
                        end else begin
                            pe_d = 1'b1;
                        end
`else
                        data_d = frame_bits;
                        fv_d   = 1'b1;
`endif
                    end else begin
                        for (int i = 1; i < SW; i++) begin
                            if (slot == 3'(i)) shadow_d[i] = din;
                        end
                        slot_d = slot + 3'd1;
                    end
                end else if (slot != 3'd0) begin
                    // The stall counter runs only while a frame is partly
                    // received.
                    if (idle_q == IDLE_LIMIT) begin
                        se_d    = 1'b1;
                        slot_d  = '0;
                        idle_d  = '0;
                        state_d = HUNT;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end

            default: state_d = HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so that
    // every register samples the values from before the edge. The shadow
    // register is small, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot         <= '0;
            shadow_q     <= '0;
            idle_q       <= '0;
            armed_q      <= 1'b0;
            {a, b, c, d} <= 4'b0000;
            frame_valid  <= 1'b0;
            sync_err     <= 1'b0;
            par_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot         <= slot_d;
            shadow_q     <= shadow_d;
            idle_q       <= idle_d;
            armed_q      <= 1'b1;
            {a, b, c, d} <= data_d;
            frame_valid  <= fv_d;
            sync_err     <= se_d;
            par_err      <= pe_d;
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4 -- directed testbench for tdm_demux4 (IDLE_TIMEOUT = 4).
// Inputs are driven on the falling edge and outputs are checked on the next
// falling edge, one rising edge later. When TDM_DEMUX4_PARITY_EN is defined,
// every frame gets a fifth parity bit and the parity scenarios are added.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

`ifdef TDM_DEMUX4_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n, din, sync, en;
    logic       a, b, c, d;
    logic [2:0] slot;
    logic       frame_valid, sync_err, par_err;

    int n_vec = 0;
    int n_err = 0;

    tdm_demux4 #(.IDLE_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sync(sync), .en(en),
        .a(a), .b(b), .c(c), .d(d), .slot(slot),
        .frame_valid(frame_valid), .sync_err(sync_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    function automatic logic bit_of(input logic [0:3] fr, input int i);
        return (i < 4) ? fr[i] : ^fr;
    endfunction

    task automatic step(input logic e, input logic s, input logic dv);
        en = e; sync = s; din = dv;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends a full frame; fr[0] is slot 0 (channel a). Adds parity if enabled.
    task automatic send_frame(input logic [0:3] fr);
        for (int i = 0; i < FLEN; i++) step(1'b1, i == 0, bit_of(fr, i));
    endtask

    task automatic test_reset;
        rst_n = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a, b, c, d, slot, frame_valid, sync_err, par_err} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b want 0", {a, b, c, d, slot, frame_valid, sync_err, par_err});
        end
        @(negedge clk);
        @(negedge clk);
        // en with sync is presented on the edge that releases reset
        en = 1'b1; sync = 1'b1; din = 1'b1;
        @(posedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (slot !== 3'd0) begin
            n_err++;
            $display("FAIL release_edge_en_ignored: slot got %0d want 0", slot);
        end
    endtask

    task automatic test_basic_frame;
        step(1'b1, 1'b1, 1'b1);
        n_vec++;
        if (slot !== 3'd1) begin
            n_err++;
            $display("FAIL basic_slot_after_sync: got %0d want 1", slot);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        n_vec++;
        if (frame_valid !== 1'b0 || {a, b, c, d} !== 4'b0000) begin
            n_err++;
            $display("FAIL basic_no_early_update: fv=%b abcd=%b want 0 0000", frame_valid, {a, b, c, d});
        end
        step(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX4_PARITY_EN
        step(1'b1, 1'b0, 1'b1);
`endif
        n_vec++;
        if ({frame_valid, a, b, c, d, slot} !== {1'b1, 4'b1011, 3'd0}) begin
            n_err++;
            $display("FAIL basic_frame: fv/abcd/slot got %b %b %0d want 1 1011 0", frame_valid, {a, b, c, d}, slot);
        end
        step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (frame_valid !== 1'b0 || {a, b, c, d} !== 4'b1011) begin
            n_err++;
            $display("FAIL basic_pulse_end: fv=%b abcd=%b want 0 1011", frame_valid, {a, b, c, d});
        end
    endtask

    task automatic test_back_to_back;
        logic [0:3] fr0, fr1, fr;
        int pulses = 0;
        int first_k = -1;
        int last_k = -1;
        fr0 = 4'b1100;
        fr1 = 4'b0011;
        for (int k = 0; k < 2 * FLEN; k++) begin
            fr = (k < FLEN) ? fr0 : fr1;
            step(1'b1, (k % FLEN) == 0, bit_of(fr, k % FLEN));
            n_vec++;
            if (frame_valid !== ((k % FLEN) == FLEN - 1)) begin
                n_err++;
                $display("FAIL b2b_fv_step%0d: got %b want %b", k, frame_valid, (k % FLEN) == FLEN - 1);
            end
            if (frame_valid === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (k == FLEN - 1) begin
                n_vec++;
                if ({a, b, c, d} !== 4'b1100) begin
                    n_err++;
                    $display("FAIL b2b_first_frame: abcd got %b want 1100", {a, b, c, d});
                end
            end
        end
        n_vec++;
        if (pulses != 2 || (last_k - first_k) != FLEN || {a, b, c, d} !== 4'b0011) begin
            n_err++;
            $display("FAIL b2b_summary: pulses=%0d gap=%0d abcd=%b want 2 %0d 0011", pulses, last_k - first_k, {a, b, c, d}, FLEN);
        end
    endtask

    task automatic test_early_sync;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);   // sync arrives at slot 2
        n_vec++;
        if ({sync_err, frame_valid, slot, a, b, c, d} !== {1'b1, 1'b0, 3'd1, 4'b0011}) begin
            n_err++;
            $display("FAIL early_sync: se/fv/slot/abcd got %b %b %0d %b want 1 0 1 0011", sync_err, frame_valid, slot, {a, b, c, d});
        end
        step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (sync_err !== 1'b0) begin
            n_err++;
            $display("FAIL early_sync_pulse_end: se got %b want 0", sync_err);
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
`ifdef TDM_DEMUX4_PARITY_EN
        step(1'b1, 1'b0, 1'b0);
`endif
        n_vec++;
        if ({frame_valid, a, b, c, d} !== {1'b1, 4'b1010}) begin
            n_err++;
            $display("FAIL early_sync_recovery: fv/abcd got %b %b want 1 1010", frame_valid, {a, b, c, d});
        end
    endtask

    task automatic test_slot0_fault;
        step(1'b1, 1'b0, 1'b1);   // slot 0 without sync while in RECV
        n_vec++;
        if (sync_err !== 1'b1 || slot !== 3'd0) begin
            n_err++;
            $display("FAIL slot0_nosync: se/slot got %b %0d want 1 0", sync_err, slot);
        end
        step(1'b1, 1'b0, 1'b1);   // now hunting: silently discarded
        n_vec++;
        if (sync_err !== 1'b0 || slot !== 3'd0 || {a, b, c, d} !== 4'b1010) begin
            n_err++;
            $display("FAIL hunt_discard: se/slot/abcd got %b %0d %b want 0 0 1010", sync_err, slot, {a, b, c, d});
        end
    endtask

    task automatic test_timeout;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_vec++;
            if (sync_err !== (i == 4) || slot !== ((i == 4) ? 3'd0 : 3'd2)) begin
                n_err++;
                $display("FAIL timeout_idle%0d: se/slot got %b %0d want %b %0d", i, sync_err, slot, i == 4, (i == 4) ? 0 : 2);
            end
        end
        step(1'b1, 1'b0, 1'b1);
        n_vec++;
        if (sync_err !== 1'b0 || slot !== 3'd0 || {a, b, c, d} !== 4'b1010) begin
            n_err++;
            $display("FAIL timeout_hunt: se/slot/abcd got %b %0d %b want 0 0 1010", sync_err, slot, {a, b, c, d});
        end
        // no stall timeout while hunting
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_vec++;
            if (sync_err !== 1'b0) begin
                n_err++;
                $display("FAIL hunt_idle%0d: se got %b want 0", i, sync_err);
            end
        end
    endtask

`ifdef TDM_DEMUX4_PARITY_EN
    task automatic test_parity;
        send_frame(4'b0110);
        n_vec++;
        if ({frame_valid, a, b, c, d} !== {1'b1, 4'b0110}) begin
            n_err++;
            $display("FAIL parity_setup: fv/abcd got %b %b want 1 0110", frame_valid, {a, b, c, d});
        end
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);   // wrong parity
        n_vec++;
        if ({par_err, sync_err, frame_valid, slot, a, b, c, d} !== {1'b1, 1'b0, 1'b0, 3'd0, 4'b0110}) begin
            n_err++;
            $display("FAIL parity_bad: pe/se/fv/slot/abcd got %b %b %b %0d %b want 1 0 0 0 0110", par_err, sync_err, frame_valid, slot, {a, b, c, d});
        end
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);   // correct parity
        n_vec++;
        if ({par_err, frame_valid, a, b, c, d} !== {1'b0, 1'b1, 4'b1010}) begin
            n_err++;
            $display("FAIL parity_good: pe/fv/abcd got %b %b %b want 0 1 1010", par_err, frame_valid, {a, b, c, d});
        end
        // wrong parity bit that also carries sync: the parity fault wins
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        n_vec++;
        if ({par_err, sync_err, slot, a, b, c, d} !== {1'b1, 1'b0, 3'd1, 4'b1010}) begin
            n_err++;
            $display("FAIL parity_precedence: pe/se/slot/abcd got %b %b %0d %b want 1 0 1 1010", par_err, sync_err, slot, {a, b, c, d});
        end
    endtask
`endif

    task automatic test_reset_mid_frame;
        send_frame(4'b1111);
        n_vec++;
        if ({frame_valid, a, b, c, d} !== {1'b1, 4'b1111}) begin
            n_err++;
            $display("FAIL rst_setup: fv/abcd got %b %b want 1 1111", frame_valid, {a, b, c, d});
        end
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a, b, c, d, slot, frame_valid, sync_err, par_err} !== 10'd0) begin
            n_err++;
            $display("FAIL rst_async: got %b want 0", {a, b, c, d, slot, frame_valid, sync_err, par_err});
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk) rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < FLEN; i++) begin
            step(1'b1, 1'b0, 1'b1);
            n_vec++;
            if (frame_valid !== 1'b0 || slot !== 3'd0) begin
                n_err++;
                $display("FAIL rst_nosync_frame%0d: fv/slot got %b %0d want 0 0", i, frame_valid, slot);
            end
        end
        n_vec++;
        if ({a, b, c, d} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_outputs_hold: abcd got %b want 0000", {a, b, c, d});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_early_sync();
        test_slot0_fault();
        test_timeout();
`ifdef TDM_DEMUX4_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
